// File: rtl/echo_range_pkg.sv
// echo_range_pkg: shared types and default constants for the echo range meter.
//   echo_state_t : measurement FSM states, also exported on the debug port
//   CM_DIV_DEF   : microseconds of round-trip echo per centimetre
//   MAX_US_DEF   : echo-wait / echo-high timeout in microseconds
package echo_range_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MEASURE = 3'd2,
    DIVIDE  = 3'd3,
    DONE    = 3'd4
  } echo_state_t;

  localparam int CM_DIV_DEF = 58;
  localparam int MAX_US_DEF = 30000;

endpackage

// File: rtl/echo_sync.sv
// echo_sync: brings the asynchronous sensor echo into the clk domain and
// produces registered single-cycle edge strobes.
//   clk, rst_n : clock, asynchronous active-low reset
//   echo       : raw asynchronous echo pin
//   echo_rise  : one-cycle strobe, 3 clk edges after a rising pin edge
//   echo_fall  : one-cycle strobe, 3 clk edges after a falling pin edge
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic echo_rise,
  output logic echo_fall
);

  logic sync_0;
  logic sync_1;
  logic sync_prev;

  // Two metastability flops, then a history flop; the strobes are
  // registered so downstream logic sees a clean, glitch-free pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      sync_prev <= 1'b0;
      echo_rise <= 1'b0;
      echo_fall <= 1'b0;
    end else begin
      sync_0    <= echo;
      sync_1    <= sync_0;
      sync_prev <= sync_1;
      echo_rise <= sync_1 & ~sync_prev;
      echo_fall <= ~sync_1 & sync_prev;
    end
  end

endmodule

// File: rtl/echo_range_meter.sv
// echo_range_meter: times the HC-SR04 echo pulse in microseconds after each
// trigger burst and converts it to whole centimetres for the LED stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   trig       : trigger pulse (clk-synchronous); its falling edge arms a measurement
//   echo       : raw asynchronous sensor echo
//   dist_cm    : last valid distance in cm (saturating)
//   dist_valid : one-cycle strobe when dist_cm updates
//   timeout    : one-cycle strobe when a measurement is abandoned
//   near       : proximity flag with hysteresis, updated on dist_valid
//   busy       : high whenever the FSM is not in IDLE
//   fsm_state  : current FSM state, for observation only
// Optional build macro ECHO_AVG4_EN: dist_cm becomes the floor mean of the
// last four quotients (history cleared at reset, timeouts not recorded).
// All outputs are plain strobes/levels; there is no back-pressure.
module echo_range_meter
  import echo_range_pkg::*;
#(
  parameter int TICKS_PER_US = 12,
  parameter int MAX_US       = MAX_US_DEF,
  parameter int CM_DIV       = CM_DIV_DEF,
  parameter int NEAR_CM      = 20,
  parameter int HYST_CM      = 2,
  parameter int DIST_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              echo,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              near,
  output logic              busy,
  output echo_state_t       fsm_state
);

  localparam int CNT_W = $clog2(MAX_US + 1);
  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_US - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0]  DIV_C    = CNT_W'(CM_DIV);
  localparam logic [DIST_W-1:0] DIST_SAT = '1;
  localparam logic [DIST_W-1:0] NEAR_C   = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] REL_C    = DIST_W'(NEAR_CM + HYST_CM);

  echo_state_t       state;
  logic              trig_d;
  logic              trig_fall;
  logic              echo_rise;
  logic              echo_fall;
  logic [PRE_W-1:0]  presc;
  logic              us_tick;
  logic [CNT_W-1:0]  us_cnt;
  logic [CNT_W-1:0]  us_cnt_nxt;
  logic              at_max;
  logic [CNT_W-1:0]  rem;
  logic [DIST_W-1:0] quo;
  logic              div_done;
  logic [DIST_W-1:0] dist_new;

  echo_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .echo      (echo),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  assign trig_fall = trig_d & ~trig;
  assign us_tick   = (presc == PRE_LAST);
  // Count including the tick of the current cycle, so the width captured on
  // echo_fall covers every microsecond the echo was high.
  assign us_cnt_nxt = (us_tick && (us_cnt != CNT_MAX)) ? us_cnt + 1'b1 : us_cnt;
  assign at_max     = (us_cnt_nxt == CNT_MAX);
  assign div_done   = (state == DIVIDE) && (rem < DIV_C);
  assign fsm_state  = state;

`ifdef ECHO_AVG4_EN
  logic [DIST_W-1:0] hist [3];
  logic [DIST_W+1:0] avg_sum;

  always_comb begin
    avg_sum  = {2'b00, quo} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    dist_new = avg_sum[DIST_W+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '{default: '0};
    end else if (div_done) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= quo;
    end
  end
`else
  always_comb dist_new = quo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_d     <= 1'b0;
      presc      <= '0;
      us_cnt     <= '0;
      rem        <= '0;
      quo        <= '0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      near       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      trig_d     <= trig;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      presc      <= us_tick ? '0 : presc + 1'b1;
      us_cnt     <= us_cnt_nxt;
      case (state)
        IDLE: begin
          presc  <= '0;
          us_cnt <= '0;
          if (trig_fall) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          // echo_rise outranks a coincident timeout and a re-arm.
          if (echo_rise) begin
            state  <= MEASURE;
            presc  <= '0;
            us_cnt <= '0;
          end else if (at_max) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
            near    <= 1'b0;
            presc   <= '0;
            us_cnt  <= '0;
          end else if (trig_fall) begin
            presc  <= '0;
            us_cnt <= '0;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state <= DIVIDE;
            presc <= '0;
            rem   <= us_cnt_nxt;
            quo   <= '0;
          end else if (at_max) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
            near    <= 1'b0;
            presc   <= '0;
            us_cnt  <= '0;
          end
        end
        DIVIDE: begin
          presc  <= '0;
          us_cnt <= '0;
          if (rem >= DIV_C) begin
            rem <= rem - DIV_C;
            if (quo != DIST_SAT) quo <= quo + 1'b1;
          end else begin
            state      <= DONE;
            dist_cm    <= dist_new;
            dist_valid <= 1'b1;
            if (dist_new < NEAR_C)       near <= 1'b1;
            else if (dist_new >= REL_C)  near <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          presc  <= '0;
          us_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_range_meter.sv
// tb_echo_range_meter: two instances of echo_range_meter. Instance 0 runs at
// 12 ticks/us for the directed distance/hysteresis table; instance 1 runs at
// 2 ticks/us with a short timeout for timeout, reset, ignore-trig and random
// measurements. Expected distances come from floor(us/58) (optionally the
// 4-entry mean) and the near hysteresis rule.
module tb_echo_range_meter;
  import echo_range_pkg::*;

  localparam int DW = 10;

  logic clk = 1'b0;
  logic trig_s [2];
  logic echo_s [2];
  logic rst_s  [2];
  logic [DW-1:0] dist_s [2];
  logic dv_s [2];
  logic to_s [2];
  logic near_s [2];
  logic busy_s [2];
  echo_state_t st_s [2];

  int checks = 0;
  int errors = 0;
  int dv_cnt [2] = '{0, 0};
  int to_cnt [2] = '{0, 0};
  int to_exp [2] = '{0, 0};
  logic [DW-1:0] exp_q_a [$];
  logic [DW-1:0] exp_q_b [$];

  // reference model state
  int dist_m [2] = '{0, 0};
  int near_m [2] = '{0, 0};
  int hist_m [2][4];

  always #5 clk = ~clk;

  echo_range_meter #(.TICKS_PER_US(12), .MAX_US(2400)) u_a (
    .clk(clk), .rst_n(rst_s[0]), .trig(trig_s[0]), .echo(echo_s[0]),
    .dist_cm(dist_s[0]), .dist_valid(dv_s[0]), .timeout(to_s[0]),
    .near(near_s[0]), .busy(busy_s[0]), .fsm_state(st_s[0])
  );

  echo_range_meter #(.TICKS_PER_US(2), .MAX_US(700)) u_b (
    .clk(clk), .rst_n(rst_s[1]), .trig(trig_s[1]), .echo(echo_s[1]),
    .dist_cm(dist_s[1]), .dist_valid(dv_s[1]), .timeout(to_s[1]),
    .near(near_s[1]), .busy(busy_s[1]), .fsm_state(st_s[1])
  );

  function automatic int tpu(input int u);
    return (u == 0) ? 12 : 2;
  endfunction

  function automatic int max_us(input int u);
    return (u == 0) ? 2400 : 700;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: raw quotient, optional mean of last four, hysteresis on near.
  task automatic model_result(input int u, input int echo_us, output int q);
    int d;
    q = echo_us / 58;
    if (q > 1023) q = 1023;
`ifdef ECHO_AVG4_EN
    hist_m[u][3] = hist_m[u][2];
    hist_m[u][2] = hist_m[u][1];
    hist_m[u][1] = hist_m[u][0];
    hist_m[u][0] = q;
    d = (hist_m[u][0] + hist_m[u][1] + hist_m[u][2] + hist_m[u][3]) / 4;
`else
    d = q;
`endif
    if (d < 20) near_m[u] = 1;
    else if (d >= 22) near_m[u] = 0;
    dist_m[u] = d;
    if (u == 0) exp_q_a.push_back(DW'(d));
    else        exp_q_b.push_back(DW'(d));
  endtask

  task automatic model_reset(input int u);
    dist_m[u] = 0;
    near_m[u] = 0;
    for (int i = 0; i < 4; i++) hist_m[u][i] = 0;
  endtask

  task automatic pulse_trig(input int u);
    trig_s[u] = 1'b1;
    step(2);
    trig_s[u] = 1'b0;
  endtask

  // Full measurement: trig fall, gap, echo high for echo_us, then checks the
  // dist_valid latency and the resulting near flag.
  task automatic do_meas(input int u, input int gap_us, input int echo_us);
    int q;
    int lat;
    pulse_trig(u);
    step(gap_us * tpu(u));
    echo_s[u] = 1'b1;
    step(echo_us * tpu(u));
    model_result(u, echo_us, q);
    echo_s[u] = 1'b0;
    lat = 0;
    for (int k = 1; k <= q + 60; k++) begin
      step(1);
      if (dv_s[u]) begin
        lat = k;
        break;
      end
    end
    check($sformatf("dv_latency_u%0d_%0dus", u, echo_us), lat, q + 5);
    check($sformatf("near_u%0d_%0dus", u, echo_us), int'(near_s[u]), near_m[u]);
    step(2);
    check($sformatf("busy_after_u%0d", u), int'(busy_s[u]), 0);
  endtask

  // Scoreboard: every dist_valid must match the oldest expected distance.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (to_s[u]) to_cnt[u]++;
      if (dv_s[u]) begin
        dv_cnt[u]++;
        if ((u == 0 && exp_q_a.size() == 0) || (u == 1 && exp_q_b.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dist_valid_u%0d: got dist_valid=1 dist_cm=%0d, required no strobe", u, dist_s[u]);
        end else if (u == 0) begin
          check("dist_cm_sb_u0", int'(dist_s[0]), int'(exp_q_a.pop_front()));
        end else begin
          check("dist_cm_sb_u1", int'(dist_s[1]), int'(exp_q_b.pop_front()));
        end
        if (to_s[u]) check($sformatf("dv_and_timeout_u%0d", u), 1, 0);
      end
    end
  end

  typedef struct {
    int gap_us;
    int echo_us;
    int exp_dist;
    int exp_near;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int dv0;
    int e;
    int g;
`ifdef ECHO_AVG4_EN
    tbl[0] = '{200,  580,  2, 1};
    tbl[1] = '{5,   1160,  7, 1};
    tbl[2] = '{5,   1740, 15, 1};
    tbl[3] = '{5,   2320, 25, 0};
`else
    tbl[0] = '{200, 1160, 20, 0};
    tbl[1] = '{5,   1100, 18, 1};
    tbl[2] = '{5,   1218, 21, 1};
    tbl[3] = '{5,   1276, 22, 0};
`endif
    for (int u = 0; u < 2; u++) begin
      trig_s[u] = 1'b0;
      echo_s[u] = 1'b0;
      rst_s[u]  = 1'b0;
      model_reset(u);
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_dist_u%0d", u), int'(dist_s[u]), 0);
      check($sformatf("rst_dv_u%0d", u), int'(dv_s[u]), 0);
      check($sformatf("rst_to_u%0d", u), int'(to_s[u]), 0);
      check($sformatf("rst_near_u%0d", u), int'(near_s[u]), 0);
      check($sformatf("rst_busy_u%0d", u), int'(busy_s[u]), 0);
    end
    step(3);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    step(3);

    // Directed distance / hysteresis table on the 12 ticks/us instance.
    for (int i = 0; i < 4; i++) begin
      do_meas(0, tbl[i].gap_us, tbl[i].echo_us);
      check($sformatf("tbl%0d_dist", i), int'(dist_s[0]), tbl[i].exp_dist);
      check($sformatf("tbl%0d_near", i), int'(near_s[0]), tbl[i].exp_near);
    end
    check("tbl_dv_count", dv_cnt[0], 4);

    // Set near on instance 1, then no echo: timeout exactly MAX_US after trig fall.
    do_meas(1, 5, 300);
    check("near_before_timeout", int'(near_s[1]), 1);
    pulse_trig(1);
    step(max_us(1) * tpu(1));
    check("noecho_to_early", int'(to_s[1]), 0);
    step(1);
    check("noecho_to_pulse", int'(to_s[1]), 1);
    near_m[1] = 0;
    to_exp[1]++;
    check("noecho_near", int'(near_s[1]), near_m[1]);
    check("noecho_dist_kept", int'(dist_s[1]), dist_m[1]);
    step(1);
    check("noecho_to_one_cycle", int'(to_s[1]), 0);
    check("noecho_busy", int'(busy_s[1]), 0);

    // Echo held high: timeout after MAX_US of high time.
    pulse_trig(1);
    step(5 * tpu(1));
    echo_s[1] = 1'b1;
    step(3 + max_us(1) * tpu(1));
    check("held_to_early", int'(to_s[1]), 0);
    step(1);
    check("held_to_pulse", int'(to_s[1]), 1);
    to_exp[1]++;
    echo_s[1] = 1'b0;
    step(10);
    check("held_busy", int'(busy_s[1]), 0);

    // Echo already high when armed: the measurement times out.
    echo_s[1] = 1'b1;
    step(10);
    pulse_trig(1);
    step(max_us(1) * tpu(1) + 1);
    check("prehigh_to_pulse", int'(to_s[1]), 1);
    to_exp[1]++;
    echo_s[1] = 1'b0;
    step(10);

    // A second trig during DIVIDE is ignored; exactly one dist_valid.
    dv0 = dv_cnt[1];
    pulse_trig(1);
    step(5 * tpu(1));
    echo_s[1] = 1'b1;
    step(580 * tpu(1));
    model_result(1, 580, e);
    echo_s[1] = 1'b0;
    step(5);
    check("divide_state", int'(st_s[1]), int'(DIVIDE));
    trig_s[1] = 1'b1;
    step(1);
    trig_s[1] = 1'b0;
    step(30);
    check("divide_trig_dv_once", dv_cnt[1] - dv0, 1);
    check("divide_trig_idle", int'(busy_s[1]), 0);

    // Asynchronous reset in the middle of MEASURE.
    pulse_trig(1);
    step(5 * tpu(1));
    echo_s[1] = 1'b1;
    step(100);
    check("mid_measure_state", int'(st_s[1]), int'(MEASURE));
    #2;
    rst_s[1]  = 1'b0;
    echo_s[1] = 1'b0;
    #1;
    model_reset(1);
    check("async_rst_dist", int'(dist_s[1]), 0);
    check("async_rst_near", int'(near_s[1]), 0);
    check("async_rst_busy", int'(busy_s[1]), 0);
    check("async_rst_state", int'(st_s[1]), int'(IDLE));
    step(2);
    rst_s[1] = 1'b1;
    step(3);
    do_meas(1, 5, 580);
    check("post_rst_dist", int'(dist_s[1]), dist_m[1]);

    // Randomized measurements against the model.
    for (int i = 0; i < 8; i++) begin
      e = $urandom_range(1, 400);
      g = $urandom_range(1, 50);
      do_meas(1, g, e);
      check($sformatf("rand%0d_dist_%0dus", i, e), int'(dist_s[1]), dist_m[1]);
    end

    step(5);
    check("sb_empty_u0", exp_q_a.size(), 0);
    check("sb_empty_u1", exp_q_b.size(), 0);
    check("timeout_count_u0", to_cnt[0], to_exp[0]);
    check("timeout_count_u1", to_cnt[1], to_exp[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/echo_range_meter.md
# echo_range_meter

Measures the HC-SR04 echo pulse width in microseconds after each trigger burst and converts it to whole centimetres. Sits directly downstream of the trigger generator and replaces the raw echo counter feeding the LED control logic. Provides a validated distance word, a timeout flag and a hysteretic proximity output for the LED stage.

## Interface

- `TICKS_PER_US`, 12: clock cycles per microsecond.
- `MAX_US`, 30000: echo-wait and echo-high timeout, in µs.
- `CM_DIV`, 58: µs per cm of round-trip distance.
- `NEAR_CM`, 20: proximity set threshold, in cm.
- `HYST_CM`, 2: proximity release hysteresis, in cm.
- `DIST_W`, 10: distance output width.

- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `trig` input 1: trigger pulse from the trigger generator, synchronous to `clk`.
- `echo` input 1: raw sensor echo, asynchronous.
- `dist_cm` output DIST_W: last valid distance, floor(µs / CM_DIV).
- `dist_valid` output 1: one-cycle strobe when `dist_cm` updates.
- `timeout` output 1: one-cycle strobe when a measurement is abandoned.
- `near` output 1: proximity flag with hysteresis; drives the LED.
- `busy` output 1: high in every state except IDLE.

## Operation

- `echo` passes through a 2-flop synchronizer and then an edge detector that produces `echo_rise` and `echo_fall`.
- A prescaler generates `us_tick` every TICKS_PER_US cycles. The prescaler is cleared on every state entry.
- IDLE:
  - A falling edge of `trig` moves the FSM to ARMED.
  - `us_cnt` and the prescaler are cleared on that transition.
- ARMED:
  - `us_cnt` increments on `us_tick`.
  - `echo_rise` moves the FSM to MEASURE and clears `us_cnt`.
  - If `us_cnt` reaches MAX_US, the block pulses `timeout` and returns to IDLE.
  - A new `trig` falling edge re-arms: `us_cnt` is cleared and the FSM stays in ARMED.
- MEASURE:
  - `us_cnt` increments on `us_tick`.
  - `echo_fall` moves the FSM to DIVIDE.
  - If `us_cnt` reaches MAX_US, the block pulses `timeout` and returns to IDLE.
  - `trig` is ignored.
- DIVIDE:
  - Division is by repeated subtraction. While `rem` ≥ CM_DIV, each cycle performs `rem` -= CM_DIV and `quo` += 1.
  - When `rem` < CM_DIV, the FSM moves to DONE. `trig` is ignored.
- DONE (1 cycle):
  - `dist_cm` ← `quo`, saturated at 2^DIST_W−1.
  - `dist_valid` pulses and the FSM returns to IDLE.
- `near` updates only on `dist_valid`:
  - Set when `dist_cm` < NEAR_CM.
  - Cleared when `dist_cm` ≥ NEAR_CM+HYST_CM.
  - Held otherwise.
  - `timeout` forces `near` to 0.
- Width rules:
  - `us_cnt` is ceil(log2(MAX_US+1)) bits and saturates at MAX_US.
  - `quo` is DIST_W bits.
  - An echo of 0 µs yields `dist_cm` = 0.

## Timing

- Reset values: `dist_cm` = 0, `dist_valid` = 0, `timeout` = 0, `near` = 0, `busy` = 0, FSM = IDLE, synchronizer flops = 0.
- Pin-to-edge latency: an `echo` pin edge produces `echo_rise`/`echo_fall` 3 `clk` edges later.
- Measurement latency: `dist_valid` asserts floor(us/CM_DIV)+2 cycles after `echo_fall`.
- `dist_valid` and `timeout` never assert in the same cycle.
- `echo_rise` and timeout in the same ARMED cycle: `echo_rise` wins.
- `echo_fall` and timeout in the same MEASURE cycle: `echo_fall` wins.
- Echo already high on arming: no rise is seen, so the measurement times out.
- `rst_n` asserted mid-measurement: outputs take their reset values immediately and the measurement is lost.

## Configuration

- `ECHO_AVG4_EN` defined:
  - `dist_cm` is the floor mean of the last 4 valid quotients, held in a 4-entry shift register.
  - The register is cleared at reset; the first three results average against zeros.
  - `near` uses the averaged value.
  - `timeout` does not enter the history.
- `ECHO_AVG4_EN` undefined: `dist_cm` is the raw quotient and no history registers exist.

## Structure

- Package `echo_range_pkg` holds:
  - The FSM state enum: IDLE, ARMED, MEASURE, DIVIDE, DONE.
  - The default constants CM_DIV_DEF and MAX_US_DEF.
- Sub-module `echo_sync`: 2-flop synchronizer plus rise/fall edge detector with active-low async reset. It is the only sub-module.

## Test plan

- Test parameters: TICKS_PER_US=12. `trig` falls, `echo` rises 200 µs later and stays high 1160 µs → `dist_valid` once, `dist_cm` = 20, `near` = 0.
- Echo high 1100 µs → `dist_cm` = 18 and `near` = 1. Then 1218 µs → 21, `near` stays 1. Then 1276 µs → 22, `near` = 0.
- No echo after `trig` → `timeout` pulses exactly MAX_US µs after the `trig` fall; `dist_cm` is unchanged and `near` = 0.
- Echo held high → `timeout` after MAX_US µs of high time. A second `trig` during DIVIDE is ignored, with one `dist_valid` only.
- `rst_n` pulsed low mid-MEASURE → all outputs reset asynchronously. The next full cycle with 580 µs echo → `dist_cm` = 10.
- With `ECHO_AVG4_EN`: echoes of 580, 1160, 1740, 2320 µs → `dist_cm` sequence 2, 7, 15, 25.
